// File: rtl/conv_kernel_loader_if.sv
// Purpose: command, ROM-read and kernel-write signals of conv_kernel_loader.
// Ports (as seen from the loader, modport slave):
//   in : enable, kernel_cmd[1:0], rom_data[DATA_WIDTH]
//   out: rom_rd_en, rom_addr[ADDR_WIDTH], kernel_wr_en, kernel_wr_idx[3:0],
//        kernel_wr_data[DATA_WIDTH], kernel_sel[1:0], kernel_ack[1:0],
//        last_kernel, busy
// The master modport is the controller/ROM side.
interface conv_kernel_loader_if #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 6
);
  logic                  enable;
  logic [1:0]            kernel_cmd;
  logic                  rom_rd_en;
  logic [ADDR_WIDTH-1:0] rom_addr;
  logic [DATA_WIDTH-1:0] rom_data;
  logic                  kernel_wr_en;
  logic [3:0]            kernel_wr_idx;
  logic [DATA_WIDTH-1:0] kernel_wr_data;
  logic [1:0]            kernel_sel;
  logic [1:0]            kernel_ack;
  logic                  last_kernel;
  logic                  busy;

  modport master (
    output enable, kernel_cmd, rom_data,
    input  rom_rd_en, rom_addr, kernel_wr_en, kernel_wr_idx, kernel_wr_data,
           kernel_sel, kernel_ack, last_kernel, busy
  );

  modport slave (
    input  enable, kernel_cmd, rom_data,
    output rom_rd_en, rom_addr, kernel_wr_en, kernel_wr_idx, kernel_wr_data,
           kernel_sel, kernel_ack, last_kernel, busy
  );
endinterface

// File: rtl/conv_kernel_loader.sv
// Purpose: loads one KERNEL_SIZE x KERNEL_SIZE kernel from the weight ROM into
// the kernel array per LOAD command, walking kernel index 0..TOTAL_WEIGHT-1
// with wrap-around; RESTART returns the index to 0.
// Ports:
//   clk    : rising-edge clock
//   rst    : synchronous active-high reset
//   bus_if : conv_kernel_loader_if.slave (command, ROM read, kernel write,
//            ack/last_kernel/busy status)
module conv_kernel_loader #(
  parameter int unsigned KERNEL_SIZE  = 3,
  parameter int unsigned TOTAL_WEIGHT = 4,
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned ADDR_WIDTH   = 6,
  parameter int unsigned BASE_ADDR    = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  conv_kernel_loader_if.slave  bus_if
);

  localparam int unsigned KERNEL_WORDS = KERNEL_SIZE * KERNEL_SIZE;
  localparam int unsigned IDX_W        = 4;
  localparam int unsigned KIDX_W       = 2;
  localparam int unsigned LAST_WORD    = KERNEL_WORDS - 1;
  localparam int unsigned LAST_KIDX    = TOTAL_WEIGHT - 1;

  localparam logic [1:0] CMD_LOAD    = 2'd1;
  localparam logic [1:0] CMD_RESTART = 2'd2;
  localparam logic [1:0] ACK_IDLE    = 2'd0;
  localparam logic [1:0] ACK_RESTART = 2'd1;
  localparam logic [1:0] ACK_LOAD    = 2'd3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_DRAIN,
    ST_DONE,
    ST_RST_ACK
  } state_e;

  state_e                state_q, state_d;
  logic [IDX_W-1:0]      word_q, word_d;
  logic [KIDX_W-1:0]     kidx_q, kidx_d;
  logic                  rd_en_q, rd_en_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                  wr_en_q, wr_en_d;
  logic [IDX_W-1:0]      wr_idx_q, wr_idx_d;
  logic [KIDX_W-1:0]     sel_q, sel_d;
  logic [1:0]            ack_q, ack_d;
  logic                  last_q, last_d;
  logic                  busy_q, busy_d;
  logic [ADDR_WIDTH-1:0] kernel_base_c;
  logic                  accept_c;

  // ROM address of word 0 of the current kernel
  assign kernel_base_c = ADDR_WIDTH'(BASE_ADDR + (32'(kidx_q) * KERNEL_WORDS));
  assign accept_c      = bus_if.enable;

  // Next state plus next value of every registered output, so outputs line up
  // with the state they belong to.
  always_comb begin
    state_d  = state_q;
    word_d   = word_q;
    kidx_d   = kidx_q;
    rd_en_d  = 1'b0;
    addr_d   = addr_q;
    wr_en_d  = 1'b0;
    wr_idx_d = wr_idx_q;
    sel_d    = sel_q;
    ack_d    = ACK_IDLE;
    last_d   = 1'b0;
    busy_d   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (accept_c && (bus_if.kernel_cmd == CMD_LOAD)) begin
          state_d = ST_FETCH;
          word_d  = '0;
          rd_en_d = 1'b1;
          addr_d  = kernel_base_c;
          sel_d   = kidx_q;
        end else if (accept_c && (bus_if.kernel_cmd == CMD_RESTART)) begin
          state_d = ST_RST_ACK;
          ack_d   = ACK_RESTART;
        end
      end

      ST_FETCH: begin
        // write of the word read in this cycle happens next cycle
        wr_en_d  = 1'b1;
        wr_idx_d = word_q;
        sel_d    = kidx_q;
        if (word_q == IDX_W'(LAST_WORD)) begin
          state_d = ST_DRAIN;
        end else begin
          word_d  = word_q + IDX_W'(1);
          rd_en_d = 1'b1;
          addr_d  = addr_q + ADDR_WIDTH'(1);
        end
      end

      ST_DRAIN: begin
        state_d = ST_DONE;
        sel_d   = kidx_q;
        ack_d   = ACK_LOAD;
        last_d  = (kidx_q == KIDX_W'(LAST_KIDX));
      end

      ST_DONE: begin
        state_d = ST_IDLE;
        kidx_d  = (kidx_q == KIDX_W'(LAST_KIDX)) ? '0 : kidx_q + KIDX_W'(1);
      end

      ST_RST_ACK: begin
        state_d = ST_IDLE;
        kidx_d  = '0;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  // State and output registers; reset abandons any partial kernel
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      word_q   <= '0;
      kidx_q   <= '0;
      rd_en_q  <= 1'b0;
      addr_q   <= '0;
      wr_en_q  <= 1'b0;
      wr_idx_q <= '0;
      sel_q    <= '0;
      ack_q    <= ACK_IDLE;
      last_q   <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      word_q   <= word_d;
      kidx_q   <= kidx_d;
      rd_en_q  <= rd_en_d;
      addr_q   <= addr_d;
      wr_en_q  <= wr_en_d;
      wr_idx_q <= wr_idx_d;
      sel_q    <= sel_d;
      ack_q    <= ack_d;
      last_q   <= last_d;
      busy_q   <= busy_d;
    end
  end

  assign bus_if.rom_rd_en     = rd_en_q;
  assign bus_if.rom_addr      = addr_q;
  assign bus_if.kernel_wr_en  = wr_en_q;
  assign bus_if.kernel_wr_idx = wr_idx_q;
  assign bus_if.kernel_sel    = sel_q;
  assign bus_if.kernel_ack    = ack_q;
  assign bus_if.last_kernel   = last_q;
  assign bus_if.busy          = busy_q;

  // The ROM's output register is the data pipeline stage; the word is passed
  // straight through during the write cycle and held at zero otherwise.
  assign bus_if.kernel_wr_data = wr_en_q ? bus_if.rom_data : {DATA_WIDTH{1'b0}};

endmodule

// File: tb/tb_conv_kernel_loader.sv
// Bench for conv_kernel_loader: two instances (BASE_ADDR 0 and 20) share one
// command stream; a schedule-based model predicts every output cycle by cycle.
module tb_conv_kernel_loader;

  localparam int unsigned TW     = 4;
  localparam int unsigned BASE_B = 20;
  localparam int unsigned SB     = 64;

  typedef struct {
    logic rd;
    int   rw;
    logic wr;
    int   ww;
    int   ack;
    logic last;
    logic busy;
    logic kv;
    int   kern;
    logic rstv;
  } ent_t;

  logic clk;
  logic rst;
  int   cyc;
  int   n_chk;
  int   n_err;
  ent_t sb [SB];
  int   free_at;
  int   kidx_m;
  int   sel_exp;
  logic armed;
  ent_t cx;

  conv_kernel_loader_if #(.DATA_WIDTH(32), .ADDR_WIDTH(6)) ifa ();
  conv_kernel_loader_if #(.DATA_WIDTH(32), .ADDR_WIDTH(6)) ifb ();

  conv_kernel_loader #(.TOTAL_WEIGHT(TW), .BASE_ADDR(0)) u_a (
    .clk(clk), .rst(rst), .bus_if(ifa)
  );
  conv_kernel_loader #(.TOTAL_WEIGHT(TW), .BASE_ADDR(BASE_B)) u_b (
    .clk(clk), .rst(rst), .bus_if(ifb)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] rom_word(input int unsigned a);
    return 32'hC0DE_0000 | 32'(a);
  endfunction

  // ROM models: data valid exactly one cycle after a read strobe, junk otherwise
  always @(posedge clk) ifa.rom_data <= ifa.rom_rd_en ? rom_word(32'(ifa.rom_addr)) : $urandom();
  always @(posedge clk) ifb.rom_data <= ifb.rom_rd_en ? rom_word(32'(ifb.rom_addr)) : $urandom();

  function automatic ent_t blank();
    ent_t b;
    b.rd = 1'b0; b.rw = 0; b.wr = 1'b0; b.ww = 0; b.ack = 0;
    b.last = 1'b0; b.busy = 1'b0; b.kv = 1'b0; b.kern = 0; b.rstv = 1'b0;
    return b;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at cycle %0d: got 0x%0h expected 0x%0h", nm, cyc, act, exp);
    end
  endtask

  task automatic check_dut(input string t, input int unsigned base, input ent_t x,
                           input int se, input logic rd, input logic [5:0] addr,
                           input logic wr, input logic [3:0] idx, input logic [31:0] data,
                           input logic [1:0] sel, input logic [1:0] ack,
                           input logic last, input logic busy);
    chk({t, "_rom_rd_en"}, 32'(rd), 32'(x.rd));
    chk({t, "_kernel_wr_en"}, 32'(wr), 32'(x.wr));
    chk({t, "_kernel_ack"}, 32'(ack), 32'(x.ack));
    chk({t, "_last_kernel"}, 32'(last), 32'(x.last));
    chk({t, "_busy"}, 32'(busy), 32'(x.busy));
    chk({t, "_kernel_sel"}, 32'(sel), 32'(se));
    if (x.rd)
      chk({t, "_rom_addr"}, 32'(addr), 32'(base + 32'(x.kern) * 9 + 32'(x.rw)));
    if (x.wr) begin
      chk({t, "_wr_idx"}, 32'(idx), 32'(x.ww));
      chk({t, "_wr_data"}, data, rom_word(base + 32'(x.kern) * 9 + 32'(x.ww)));
    end
    if (x.rstv) begin
      chk({t, "_rst_rom_addr"}, 32'(addr), 32'd0);
      chk({t, "_rst_wr_idx"}, 32'(idx), 32'd0);
      chk({t, "_rst_wr_data"}, data, 32'd0);
    end
  endtask

  // Compare process: every cycle after the first reset, both instances vs model
  always @(negedge clk) begin
    cx = sb[cyc % SB];
    if (cx.rstv) armed = 1'b1;
    if (armed) begin
      if (cx.rstv) sel_exp = 0;
      else if (cx.kv) sel_exp = cx.kern;
      check_dut("A", 0, cx, sel_exp, ifa.rom_rd_en, ifa.rom_addr, ifa.kernel_wr_en,
                ifa.kernel_wr_idx, ifa.kernel_wr_data, ifa.kernel_sel, ifa.kernel_ack,
                ifa.last_kernel, ifa.busy);
      check_dut("B", BASE_B, cx, sel_exp, ifb.rom_rd_en, ifb.rom_addr, ifb.kernel_wr_en,
                ifb.kernel_wr_idx, ifb.kernel_wr_data, ifb.kernel_sel, ifb.kernel_ack,
                ifb.last_kernel, ifb.busy);
    end
    sb[cyc % SB] = blank();
  end

  // Apply inputs for the next edge, schedule what that edge must cause, then
  // return at the following negedge with the resulting outputs visible.
  task automatic drive(input logic r, input logic e, input logic [1:0] c);
    int m;
    m = cyc + 1;
    rst = r;
    ifa.enable = e; ifb.enable = e;
    ifa.kernel_cmd = c; ifb.kernel_cmd = c;
    if (r) begin
      for (int i = 0; i < 16; i++) sb[(m + i) % SB] = blank();
      sb[m % SB].rstv = 1'b1;
      free_at = m + 1;
      kidx_m = 0;
    end else if (e && m >= free_at && c == 2'd1) begin
      for (int i = 0; i < 9; i++) begin
        sb[(m + i) % SB].rd = 1'b1;
        sb[(m + i) % SB].rw = i;
        sb[(m + 1 + i) % SB].wr = 1'b1;
        sb[(m + 1 + i) % SB].ww = i;
      end
      for (int i = 0; i < 11; i++) begin
        sb[(m + i) % SB].busy = 1'b1;
        sb[(m + i) % SB].kv = 1'b1;
        sb[(m + i) % SB].kern = kidx_m;
      end
      sb[(m + 10) % SB].ack = 3;
      sb[(m + 10) % SB].last = (kidx_m == TW - 1);
      free_at = m + 12;
      kidx_m = (kidx_m + 1) % TW;
    end else if (e && m >= free_at && c == 2'd2) begin
      sb[m % SB].ack = 1;
      sb[m % SB].busy = 1'b1;
      free_at = m + 2;
      kidx_m = 0;
    end
    @(negedge clk);
  endtask

  // One LOAD with hand-computed address/ack expectations for both instances
  task automatic load_pinned(input int k, input logic last_exp);
    drive(1'b0, 1'b1, 2'd1);
    chk("pin_a_first_addr", 32'(ifa.rom_addr), 32'(k * 9));
    chk("pin_b_first_addr", 32'(ifb.rom_addr), 32'(BASE_B + k * 9));
    repeat (8) drive(1'b0, 1'b1, 2'd0);
    chk("pin_a_last_addr", 32'(ifa.rom_addr), 32'(k * 9 + 8));
    chk("pin_b_last_addr", 32'(ifb.rom_addr), 32'(BASE_B + k * 9 + 8));
    drive(1'b0, 1'b1, 2'd0);
    chk("pin_a_final_idx", 32'(ifa.kernel_wr_idx), 32'd8);
    chk("pin_a_final_data", ifa.kernel_wr_data, rom_word(k * 9 + 8));
    chk("pin_a_rd_after_fetch", 32'(ifa.rom_rd_en), 32'd0);
    drive(1'b0, 1'b1, 2'd0);
    chk("pin_a_ack", 32'(ifa.kernel_ack), 32'd3);
    chk("pin_a_last", 32'(ifa.last_kernel), 32'(last_exp));
    chk("pin_b_last", 32'(ifb.last_kernel), 32'(last_exp));
    chk("pin_a_sel", 32'(ifa.kernel_sel), 32'(k));
    chk("pin_a_wr_at_ack", 32'(ifa.kernel_wr_en), 32'd0);
    drive(1'b0, 1'b1, 2'd0);
    chk("pin_a_ack_cleared", 32'(ifa.kernel_ack), 32'd0);
    chk("pin_a_busy_cleared", 32'(ifa.busy), 32'd0);
  endtask

  initial begin
    int acks;
    cyc = 0; n_chk = 0; n_err = 0;
    free_at = 0; kidx_m = 0; sel_exp = 0; armed = 1'b0;
    for (int i = 0; i < SB; i++) sb[i] = blank();
    rst = 1'b1;
    ifa.enable = 1'b0; ifb.enable = 1'b0;
    ifa.kernel_cmd = 2'd0; ifb.kernel_cmd = 2'd0;
    @(negedge clk);

    // reset state
    drive(1'b1, 1'b0, 2'd0);
    drive(1'b1, 1'b0, 2'd0);
    chk("rst_busy", 32'(ifa.busy), 32'd0);
    chk("rst_rd_en", 32'(ifa.rom_rd_en), 32'd0);
    chk("rst_wr_en", 32'(ifa.kernel_wr_en), 32'd0);
    chk("rst_ack", 32'(ifa.kernel_ack), 32'd0);
    chk("rst_last", 32'(ifa.last_kernel), 32'd0);
    chk("rst_sel", 32'(ifa.kernel_sel), 32'd0);
    chk("rst_addr", 32'(ifa.rom_addr), 32'd0);

    // first load, then a second, then RESTART and a load from kernel 0
    load_pinned(0, 1'b0);
    load_pinned(1, 1'b0);
    drive(1'b0, 1'b1, 2'd2);
    chk("restart_ack", 32'(ifa.kernel_ack), 32'd1);
    drive(1'b0, 1'b1, 2'd0);
    chk("restart_ack_one_cycle", 32'(ifa.kernel_ack), 32'd0);
    load_pinned(0, 1'b0);

    // full sweep; kernel 3 flags last_kernel, then wrap to kernel 0
    drive(1'b0, 1'b1, 2'd2);
    drive(1'b0, 1'b1, 2'd0);
    load_pinned(0, 1'b0);
    load_pinned(1, 1'b0);
    load_pinned(2, 1'b0);
    load_pinned(3, 1'b1);
    load_pinned(0, 1'b0);

    // dropped commands: enable low, reserved cmd, LOAD pulse mid-load
    repeat (3) begin
      drive(1'b0, 1'b0, 2'd1);
      chk("disabled_load_busy", 32'(ifa.busy), 32'd0);
    end
    drive(1'b0, 1'b1, 2'd3);
    chk("reserved_cmd_busy", 32'(ifa.busy), 32'd0);
    acks = 0;
    drive(1'b0, 1'b1, 2'd1);
    for (int i = 1; i <= 13; i++) begin
      drive(1'b0, 1'b1, (i == 5) ? 2'd1 : 2'd0);
      if (ifa.kernel_ack == 2'd3) acks++;
    end
    chk("pulsed_load_ack_count", 32'(acks), 32'd1);

    // reset mid-FETCH, then a clean load from kernel 0
    drive(1'b0, 1'b1, 2'd1);
    repeat (5) drive(1'b0, 1'b1, 2'd0);
    drive(1'b1, 1'b1, 2'd1);
    chk("midrst_busy", 32'(ifa.busy), 32'd0);
    chk("midrst_rd_en", 32'(ifa.rom_rd_en), 32'd0);
    chk("midrst_wr_en", 32'(ifa.kernel_wr_en), 32'd0);
    chk("midrst_ack", 32'(ifa.kernel_ack), 32'd0);
    load_pinned(0, 1'b0);

    // LOAD held continuously
    repeat (40) drive(1'b0, 1'b1, 2'd1);

    // random traffic, occasional reset
    repeat (400) drive(($urandom_range(63) == 0), ($urandom_range(3) != 0),
                       2'($urandom_range(3)));
    repeat (14) drive(1'b0, 1'b0, 2'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
